// File: rtl/mmio_fifo_bridge.sv
// Host MMIO window onto NUM_CH TX/RX FIFO pairs; MMIO_FIFO_DROP_CNT_EN adds per-channel drop counters.
// Latency: TX push 1 edge; reads answer 1 cycle after accept (2 for a DATA pop); rvalid holds until rready.
// Backpressure: pushes to a full FIFO are dropped; new read requests wait while a response is pending.

// Generic first-word-fall-through FIFO with occupancy count.
// Latency: dout_o shows the head word the cycle after the push edge.
// Backpressure: push on full and pop on empty are ignored; simultaneous push/pop both apply.
module mmio_fifo_bridge_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

module mmio_fifo_bridge #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0600
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main_sync,
  input  logic                     wready,
  input  logic [31:0]              wr_addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     arvalid_q,
  input  logic [31:0]              araddr_q,
  input  logic                     rready,
  output logic                     rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  input  logic [NUM_CH-1:0]        tx_rd,
  output logic [NUM_CH*DATA_W-1:0] tx_dout,
  output logic [NUM_CH-1:0]        tx_empty,
  input  logic [NUM_CH-1:0]        rx_wr,
  input  logic [NUM_CH*DATA_W-1:0] rx_din,
  output logic [NUM_CH-1:0]        rx_full
);
  localparam int          CNT_W   = $clog2(DEPTH) + 1;
  localparam int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] WIN_LEN = 32'(16 * NUM_CH);
  localparam logic [1:0]  REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_DROPS = 2'd2;
  localparam logic [1:0]  RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, POP, RESP} state_e;

  function automatic logic [DATA_W-1:0] fit(input logic [31:0] v);
    logic [63:0] t;
    t = {32'b0, v};
    return t[DATA_W-1:0];
  endfunction

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  pop_en;

  logic [31:0]           wr_off, rd_off;
  logic                  wr_hit, rd_hit;
  logic [CH_W-1:0]       wr_ch, rd_ch;
  logic [1:0]            wr_sel, rd_sel;

  logic [NUM_CH-1:0]     tx_push, tx_full_w, rx_pop, rx_empty_w;
  logic [DATA_W-1:0]     rx_head [NUM_CH];
  logic [CNT_W-1:0]      tx_cnt  [NUM_CH];
  logic [CNT_W-1:0]      rx_cnt  [NUM_CH];

  // Windows must be word aligned; anything else falls through to SLVERR.
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = araddr_q - BASE_ADDR;
  assign wr_hit = (wr_addr >= BASE_ADDR) && (wr_off < WIN_LEN) && (wr_off[1:0] == 2'b00);
  assign rd_hit = (araddr_q >= BASE_ADDR) && (rd_off < WIN_LEN) && (rd_off[1:0] == 2'b00);
  assign wr_ch  = wr_off[4 +: CH_W];
  assign rd_ch  = rd_off[4 +: CH_W];
  assign wr_sel = wr_off[3:2];
  assign rd_sel = rd_off[3:2];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign tx_push[c] = wready && wr_hit && (wr_sel == REG_DATA) && (wr_ch == CH_W'(c));
    assign rx_pop[c]  = pop_en && (ch_q == CH_W'(c));

    mmio_fifo_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk_i   (clk_main_a0),
      .rst_i   (rst_main_sync),
      .push_i  (tx_push[c]),
      .din_i   (wdata),
      .pop_i   (tx_rd[c]),
      .dout_o  (tx_dout[c*DATA_W +: DATA_W]),
      .full_o  (tx_full_w[c]),
      .empty_o (tx_empty[c]),
      .count_o (tx_cnt[c])
    );

    mmio_fifo_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk_i   (clk_main_a0),
      .rst_i   (rst_main_sync),
      .push_i  (rx_wr[c]),
      .din_i   (rx_din[c*DATA_W +: DATA_W]),
      .pop_i   (rx_pop[c]),
      .dout_o  (rx_head[c]),
      .full_o  (rx_full[c]),
      .empty_o (rx_empty_w[c]),
      .count_o (rx_cnt[c])
    );
  end

`ifdef MMIO_FIFO_DROP_CNT_EN
  logic [15:0]       drop_q [NUM_CH];
  logic [NUM_CH-1:0] drop_clr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_drop
    logic [1:0]  inc;
    logic [16:0] sum;
    assign inc = {1'b0, tx_push[c] & tx_full_w[c]} + {1'b0, rx_wr[c] & rx_full[c]};
    assign sum = {1'b0, drop_q[c]} + 17'(inc);

    // A drop on the clearing edge survives the clear.
    always_ff @(posedge clk_main_a0) begin
      if (rst_main_sync)    drop_q[c] <= '0;
      else if (drop_clr[c]) drop_q[c] <= 16'(inc);
      else                  drop_q[c] <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end
`endif

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      state_q <= IDLE;
      rdata_q <= '0;
      rresp_q <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arvalid_q) begin
          if (rd_hit && (rd_sel == REG_DATA) && !rx_empty_w[rd_ch]) state_d = POP;
          else                                                      state_d = RESP;
        end
      end
      POP:     state_d = RESP;
      RESP:    if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid = 1'b0;
    pop_en = 1'b0;
    case (state_q)
      POP:     pop_en = 1'b1;
      RESP:    rvalid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    ch_d    = ch_q;
`ifdef MMIO_FIFO_DROP_CNT_EN
    drop_clr = '0;
`endif
    if (state_q == IDLE && arvalid_q) begin
      ch_d    = rd_ch;
      rdata_d = fit(32'hAAAA_AAAA);
      rresp_d = RESP_SLVERR;
      if (rd_hit) begin
        case (rd_sel)
          REG_DATA: begin
            if (rx_empty_w[rd_ch]) begin
              rdata_d = fit(32'hDEAD_0000);
              rresp_d = RESP_OKAY;
            end
          end
          REG_STATUS: begin
            rdata_d = fit({8'h00, 8'(rx_cnt[rd_ch]), 8'(tx_cnt[rd_ch]), 4'h0,
                           rx_full[rd_ch], rx_empty_w[rd_ch], tx_full_w[rd_ch], tx_empty[rd_ch]});
            rresp_d = RESP_OKAY;
          end
`ifdef MMIO_FIFO_DROP_CNT_EN
          REG_DROPS: begin
            rdata_d         = fit(32'(drop_q[rd_ch]));
            rresp_d         = RESP_OKAY;
            drop_clr[rd_ch] = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end else if (state_q == POP) begin
      rdata_d = rx_head[ch_q];
      rresp_d = RESP_OKAY;
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;
endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// Directed bench for mmio_fifo_bridge at default parameters (32-bit, depth 16, 4 channels, base 0x600).
module tb_mmio_fifo_bridge;
  localparam int DW = 32;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wready;
  logic [31:0]     wr_addr;
  logic [DW-1:0]   wdata;
  logic            arvalid_q;
  logic [31:0]     araddr_q;
  logic            rready;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic [NC-1:0]   tx_rd;
  logic [NC*DW-1:0] tx_dout;
  logic [NC-1:0]   tx_empty;
  logic [NC-1:0]   rx_wr;
  logic [NC*DW-1:0] rx_din;
  logic [NC-1:0]   rx_full;

  int n_vec = 0;
  int n_err = 0;

  mmio_fifo_bridge dut (
    .clk_main_a0  (clk),
    .rst_main_sync(rst),
    .wready       (wready),
    .wr_addr      (wr_addr),
    .wdata        (wdata),
    .arvalid_q    (arvalid_q),
    .araddr_q     (araddr_q),
    .rready       (rready),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rresp        (rresp),
    .tx_rd        (tx_rd),
    .tx_dout      (tx_dout),
    .tx_empty     (tx_empty),
    .rx_wr        (rx_wr),
    .rx_din       (rx_din),
    .rx_full      (rx_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    wready = 1'b1; wr_addr = a; wdata = d;
    tick();
    wready = 1'b0;
  endtask

  task automatic host_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output int lat);
    arvalid_q = 1'b1; araddr_q = a;
    tick();
    arvalid_q = 1'b0;
    lat = 1;
    while (!rvalid && lat < 10) begin
      tick();
      lat++;
    end
    if (!rvalid) chk("rd_timeout", 64'd0, 64'd1);
    d = rdata; r = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  logic [31:0] d, d0;
  logic [1:0]  r;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wready = 0; wr_addr = 0; wdata = 0; arvalid_q = 0; araddr_q = 0;
    rready = 0; tx_rd = 0; rx_wr = 0; rx_din = '0;
    tick(); tick();
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_tx_empty", 64'(tx_empty), 64'hF);
    chk("rst_rx_full", 64'(rx_full), 64'h0);
    rst = 1'b0;
    tick();

    // Single write to channel 1 DATA
    host_write(32'h610, 32'h1234_5678);
    chk("ch1_tx_empty", 64'(tx_empty), 64'b1101);
    chk("ch1_tx_dout", 64'(tx_dout[63:32]), 64'h1234_5678);
    tx_rd = 4'b0010; tick(); tx_rd = 0;
    chk("ch1_popped", 64'(tx_empty), 64'hF);

    // Writes to STATUS and outside the windows are ignored
    host_write(32'h604, 32'h1);
    host_write(32'h640, 32'h2);
    host_write(32'h5FC, 32'h3);
    chk("ignored_wr", 64'(tx_empty), 64'hF);

    // Overfill channel 0
    for (int i = 0; i < 17; i++) host_write(32'h600, 32'(i + 1));
    host_read(32'h604, d, r, lat);
    chk("full_status", 64'(d), 64'h0000_1006);
    chk("full_status_resp", 64'(r), 64'd0);
    chk("full_status_lat", 64'(lat), 64'd1);
    host_read(32'h608, d, r, lat);
`ifdef MMIO_FIFO_DROP_CNT_EN
    chk("drops_first", 64'(d), 64'd1);
    chk("drops_first_resp", 64'(r), 64'd0);
    host_read(32'h608, d, r, lat);
    chk("drops_cleared", 64'(d), 64'd0);
`else
    chk("drops_unmapped", 64'(d), 64'hAAAA_AAAA);
    chk("drops_unmapped_resp", 64'(r), 64'd2);
`endif
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tx0_order_%0d", i), 64'(tx_dout[31:0]), 64'(i + 1));
      tx_rd = 4'b0001; tick(); tx_rd = 0;
    end
    chk("tx0_drained", 64'(tx_empty[0]), 64'd1);

    // RX channel 2 reads
    rx_wr = 4'b0100; rx_din[95:64] = 32'hA; tick();
    rx_din[95:64] = 32'hB; tick();
    rx_wr = 0;
    host_read(32'h620, d, r, lat);
    chk("rx2_a", 64'(d), 64'hA);
    chk("rx2_a_lat", 64'(lat), 64'd2);
    chk("rx2_a_resp", 64'(r), 64'd0);
    host_read(32'h620, d, r, lat);
    chk("rx2_b", 64'(d), 64'hB);
    chk("rx2_b_lat", 64'(lat), 64'd2);
    host_read(32'h620, d, r, lat);
    chk("rx2_empty", 64'(d), 64'hDEAD_0000);
    chk("rx2_empty_resp", 64'(r), 64'd0);
    chk("rx2_empty_lat", 64'(lat), 64'd1);
    host_read(32'h640, d, r, lat);
    chk("outside_rd", 64'(d), 64'hAAAA_AAAA);
    chk("outside_resp", 64'(r), 64'd2);

    // Reserved read held without rready
    arvalid_q = 1'b1; araddr_q = 32'h60C;
    tick();
    chk("rsvd_rvalid", 64'(rvalid), 64'd1);
    chk("rsvd_rdata", 64'(rdata), 64'hAAAA_AAAA);
    chk("rsvd_rresp", 64'(rresp), 64'd2);
    araddr_q = 32'h604;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_rvalid_%0d", i), 64'(rvalid), 64'd1);
      chk($sformatf("hold_rdata_%0d", i), 64'(rdata), 64'hAAAA_AAAA);
    end
    rready = 1'b1; arvalid_q = 1'b0;
    tick();
    rready = 1'b0;
    chk("hold_release", 64'(rvalid), 64'd0);
    tick();
    chk("hold_no_second", 64'(rvalid), 64'd0);

    // Full RX[0] with push colliding with host pop
    rx_wr = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      rx_din[31:0] = 32'h100 + 32'(i);
      tick();
    end
    rx_wr = 0;
    chk("rx0_full", 64'(rx_full[0]), 64'd1);
    arvalid_q = 1'b1; araddr_q = 32'h600;
    tick();
    arvalid_q = 1'b0;
    chk("pop_state_rvalid", 64'(rvalid), 64'd0);
    rx_wr = 4'b0001; rx_din[31:0] = 32'hBEEF;
    tick();
    rx_wr = 0;
    chk("collide_rvalid", 64'(rvalid), 64'd1);
    chk("collide_head", 64'(rdata), 64'h100);
    chk("collide_not_full", 64'(rx_full[0]), 64'd0);
    rready = 1'b1; tick(); rready = 1'b0;
    host_read(32'h604, d, r, lat);
    chk("collide_status", 64'(d), 64'h000F_0001);
    host_read(32'h608, d, r, lat);
`ifdef MMIO_FIFO_DROP_CNT_EN
    chk("rx_drop_cnt", 64'(d), 64'd1);
`else
    chk("rx_drop_unmapped", 64'(d), 64'hAAAA_AAAA);
`endif
    host_read(32'h600, d, r, lat);
    chk("rx0_next", 64'(d), 64'h101);

    // Reset while a response is pending
    host_write(32'h630, 32'h55);
    chk("ch3_tx", 64'(tx_empty), 64'b0111);
    arvalid_q = 1'b1; araddr_q = 32'h600;
    tick();
    arvalid_q = 1'b0;
    tick();
    d0 = rdata;
    chk("pre_rst_rvalid", 64'(rvalid), 64'd1);
    chk("pre_rst_rdata", 64'(d0), 64'h102);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    chk("mid_rst_tx_empty", 64'(tx_empty), 64'hF);
    chk("mid_rst_rx_full", 64'(rx_full), 64'h0);
    tick();
    chk("mid_rst_stays_idle", 64'(rvalid), 64'd0);
    host_read(32'h600, d, r, lat);
    chk("post_rst_data", 64'(d), 64'hDEAD_0000);
    chk("post_rst_lat", 64'(lat), 64'd1);
    host_read(32'h604, d, r, lat);
    chk("post_rst_status", 64'(d), 64'h0000_0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_fifo_bridge.md
MMIO_FIFO_BRIDGE -- requirements
Module: mmio_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width of host and channel FIFO words (8..64).
REQ-002 SHALL have parameter DEPTH, default 16: entries per FIFO, power of 2, 2..256.
REQ-003 SHALL have parameter NUM_CH, default 4: number of channel pairs (1..8), each with one TX FIFO (host->user) and one RX FIFO (user->host).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0600: byte address of channel 0 window; channel c window = BASE_ADDR + 16*c.
REQ-005 SHALL have port clk_main_a0, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_main_sync, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports wready input 1 (host write strobe), wr_addr input 32, wdata input DATA_W.
REQ-008 SHALL have ports arvalid_q input 1, araddr_q input 32 (host read request).
REQ-009 SHALL have ports rready input 1, rvalid output 1, rdata output DATA_W, rresp output 2 (read response).
REQ-010 SHALL have ports tx_rd input NUM_CH, tx_dout output NUM_CH*DATA_W, tx_empty output NUM_CH (user side of TX FIFOs; channel c in slice c).
REQ-011 SHALL have ports rx_wr input NUM_CH, rx_din input NUM_CH*DATA_W, rx_full output NUM_CH (user side of RX FIFOs).

Function
REQ-012 Per-channel window offsets SHALL be: +0x0 DATA, +0x4 STATUS, +0x8 DROPS (only with macro), +0xC reserved.
REQ-013 Write with wready=1 to DATA of channel c SHALL push wdata into TX[c] if TX[c] not full at that edge; otherwise word dropped, FIFO unchanged.
REQ-014 Writes to any other address SHALL be ignored.
REQ-015 FIFOs SHALL be first-word-fall-through: tx_dout valid whenever tx_empty=0; tx_rd pops same edge; tx_rd when empty ignored.
REQ-016 rx_wr when rx_full=1 SHALL be ignored and counted as a drop on that channel.
REQ-017 Simultaneous push and pop on one FIFO SHALL both take effect except push on full (dropped) and pop on empty (ignored); occupancy changes by net amount.
REQ-018 Read FSM states SHALL be IDLE, POP, RESP; reset state IDLE.
REQ-019 IDLE: arvalid_q=1 SHALL be accepted; DATA address with RX[c] non-empty -> POP; all other addresses -> RESP with rdata loaded same edge.
REQ-020 POP: SHALL pop RX[c], load rdata with its head word, go to RESP; rvalid thus rises 2 cycles after accept for DATA reads, 1 cycle otherwise.
REQ-021 RESP: rvalid=1 held with rdata/rresp stable until rready=1; on that edge rvalid->0, state->IDLE; no new request accepted while in POP or RESP.
REQ-022 Read DATA with RX[c] empty SHALL return rdata=0xDEAD_0000 (zero-extended/truncated to DATA_W), rresp=2'b00, no pop.
REQ-023 Read STATUS SHALL return {rx_count[15:8]... bits 23:16, tx_count bits 15:8, bits 3:0 = {rx_full, rx_empty, tx_full, tx_empty}}, other bits 0, rresp=2'b00.
REQ-024 Read of unmapped/reserved address SHALL return rdata=0xAAAA_AAAA, rresp=2'b10 (SLVERR).
REQ-025 Occupancy counters SHALL be $clog2(DEPTH)+1 bits, range 0..DEPTH; pointers wrap modulo DEPTH.

Reset
REQ-026 On rst_main_sync=1 at an edge: state IDLE, rvalid=0, rdata=0, rresp=0, all FIFOs emptied (tx_empty all 1, rx_full all 0), drop counters 0.
REQ-027 Reset mid-read (POP or RESP) SHALL abort the transaction with no further rvalid; popped word is lost.

Configuration
REQ-028 Macro MMIO_FIFO_DROP_CNT_EN defined: per-channel 16-bit saturating drop counter (TX host drops + RX user drops); DROPS read returns it and clears it on the read edge (increment same edge wins: counter=1).
REQ-029 Macro undefined: no counters; DROPS offset treated as unmapped (0xAAAA_AAAA, SLVERR).

Verification
REQ-030 NUM_CH=4: write 0x1234_5678 to BASE+0x10 -> tx_empty[1]=0, tx_dout[1]=0x1234_5678 next cycle, others empty.
REQ-031 DEPTH=16: 17 writes to ch0 DATA -> tx_full[0]=1, 17th dropped; STATUS read returns tx_count=16, bit1=1; with macro DROPS read =1 then =0.
REQ-032 rx_wr[2] pushes 0xA, 0xB; read BASE+0x20 twice with rready=1 -> rdata 0xA then 0xB, rvalid 2 cycles after accept, rresp 0; third read -> 0xDEAD_0000.
REQ-033 Read BASE+0x0C -> rdata 0xAAAA_AAAA, rresp 2'b10, rvalid 1 cycle after accept; hold rready=0 5 cycles -> rvalid, rdata stable, second arvalid_q not accepted.
REQ-034 Full RX[0] with simultaneous rx_wr[0] and host pop -> pop delivers head, push dropped, occupancy DEPTH-1; rst_main_sync asserted in RESP -> rvalid=0 next edge, all FIFOs empty.
